// File: rtl/cordic_pkg.sv
// Shared types and Q16.16 constants for the CORDIC scheduler and its rotation core.
// The arctangent table is in degrees, so angles never need converting to radians.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    HOLD
  } sched_state_e;

  localparam int CORDIC_ITER  = 16;
  localparam int CORDIC_WIDTH = 32;
  localparam int DEG_ONE      = 65536;
  localparam int CORDIC_ONE   = 65536;

  // Pre-scaled start vector, 1/K = 0.607253 of CORDIC_ONE, so the results need no gain correction.
  localparam int CORDIC_GAIN  = 39797;

  function automatic logic signed [31:0] cordic_atan(input int i);
    case (i)
      0:       return 32'sd2949120;
      1:       return 32'sd1740967;
      2:       return 32'sd919879;
      3:       return 32'sd466945;
      4:       return 32'sd234379;
      5:       return 32'sd117304;
      6:       return 32'sd58666;
      7:       return 32'sd29335;
      8:       return 32'sd14668;
      9:       return 32'sd7334;
      10:      return 32'sd3667;
      11:      return 32'sd1833;
      12:      return 32'sd917;
      13:      return 32'sd458;
      14:      return 32'sd229;
      15:      return 32'sd115;
      default: return 32'sd0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_32.sv
// Iterative rotation-mode CORDIC. It loads on start, runs one micro-rotation per cycle and
// then spends one more cycle raising done. done stays high until the next start.
module cordic_32
  import cordic_pkg::*;
#(
  parameter int WIDTH = CORDIC_WIDTH,
  parameter int ITER  = CORDIC_ITER
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] angle,
  output logic                    done,
  output logic signed [WIDTH-1:0] cos_out,
  output logic signed [WIDTH-1:0] sin_out
);

  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic signed [WIDTH-1:0] GAIN = WIDTH'(CORDIC_GAIN);

  logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [WIDTH-1:0] x_sh, y_sh, atan_step;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    run_q, run_d, done_q, done_d;

  always_comb begin
    x_sh      = x_q >>> cnt_q;
    y_sh      = y_q >>> cnt_q;
    atan_step = WIDTH'(cordic_atan(int'(cnt_q)));
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    cnt_d     = cnt_q;
    run_d     = run_q;
    done_d    = done_q;
    if (start) begin
      x_d    = GAIN;
      y_d    = '0;
      z_d    = angle;
      cnt_d  = '0;
      run_d  = 1'b1;
      done_d = 1'b0;
    end else if (run_q) begin
      if (cnt_q == CNT_W'(ITER)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        // Rotate toward zero residual angle; the sign of z picks the direction.
        if (!z_q[WIDTH-1]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_step;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_step;
        end
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done    = done_q;
  assign cos_out = x_q;
  assign sin_out = y_q;

endmodule

// File: rtl/cordic_rr_scheduler.sv
// Round-robin front end that shares one cordic_32 among N_REQ requesters and returns
// tagged cos/sin results. Only one operation is in flight at a time.
module cordic_rr_scheduler
  import cordic_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = CORDIC_WIDTH,
  parameter int ITER  = CORDIC_ITER
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_angle,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic signed [WIDTH-1:0]    rsp_cos,
  output logic signed [WIDTH-1:0]    rsp_sin,
  output logic                       busy
);

  localparam int ID_W = $clog2(N_REQ);

  sched_state_e            state_q, state_d;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d, rsp_id_q, rsp_id_d, grant_idx;
  logic signed [WIDTH-1:0] angle_q, angle_d, rsp_cos_q, rsp_cos_d, rsp_sin_q, rsp_sin_d;
  logic signed [WIDTH-1:0] core_cos, core_sin;
  logic                    rsp_valid_q, rsp_valid_d, core_done, core_start;

  // Nearest valid index after ptr wins: scan far-to-near so the nearest overwrites.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                               input logic [ID_W-1:0]  ptr);
    logic [ID_W-1:0] pick;
    int              idx;
    pick = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      idx = (int'(ptr) + off) % N_REQ;
      if (valid[idx]) pick = ID_W'(idx);
    end
    return pick;
  endfunction

  always_comb begin
    grant_idx   = rr_pick(req_valid, rr_ptr_q);
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    angle_d     = angle_q;
    rsp_id_d    = rsp_id_q;
    rsp_cos_d   = rsp_cos_q;
    rsp_sin_d   = rsp_sin_q;
    rsp_valid_d = rsp_valid_q;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[grant_idx] = !rst;
          angle_d  = req_angle[int'(grant_idx)*WIDTH +: WIDTH];
          rsp_id_d = grant_idx;
          rr_ptr_d = grant_idx;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: state_d = RUN;
      RUN: begin
        if (core_done) begin
          rsp_cos_d   = core_cos;
          rsp_sin_d   = core_sin;
          rsp_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= ID_W'(N_REQ - 1);
      angle_q     <= '0;
      rsp_id_q    <= '0;
      rsp_cos_q   <= '0;
      rsp_sin_q   <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      angle_q     <= angle_d;
      rsp_id_q    <= rsp_id_d;
      rsp_cos_q   <= rsp_cos_d;
      rsp_sin_q   <= rsp_sin_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign core_start = (state_q == LAUNCH);

  cordic_32 #(
    .WIDTH (WIDTH),
    .ITER  (ITER)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (core_start),
    .angle   (angle_q),
    .done    (core_done),
    .cos_out (core_cos),
    .sin_out (core_sin)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_cos   = rsp_cos_q;
  assign rsp_sin   = rsp_sin_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Scoreboard bench for cordic_rr_scheduler: stimulus pushes hand-computed results, a monitor
// pops and compares them on each response handshake.
module tb_cordic_rr_scheduler;

  localparam int N_REQ = 4;
  localparam int WIDTH = 32;
  localparam int TOL   = 64;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*WIDTH-1:0]  req_angle;
  logic [N_REQ-1:0]        req_ready;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [1:0]              rsp_id;
  logic signed [WIDTH-1:0] rsp_cos;
  logic signed [WIDTH-1:0] rsp_sin;
  logic                    busy;

  typedef struct {
    int id;
    int c;
    int s;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Angles 0/10/20/30 degrees in Q16.16 with their rounded cos/sin.
  int ang_tab[4] = '{0, 655360, 1310720, 1966080};
  int cos_tab[4] = '{65536, 64540, 61585, 56756};
  int sin_tab[4] = '{0, 11380, 22415, 32768};

  cordic_rr_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ITER(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_angle (req_angle),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_cos   (rsp_cos),
    .rsp_sin   (rsp_sin),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic checkNear(input string name, input int act, input int req);
    int d;
    d = act - req;
    if (d < 0) d = -d;
    n_cmp++;
    if (d > TOL) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d +/- %0d (cycle %0d)", name, act, req, TOL, cyc);
    end
  endtask

  task automatic pushExp(input int id, input int c, input int s);
    exp_t e;
    e.id = id;
    e.c  = c;
    e.s  = s;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: samples well after the negedge drives and before the next posedge.
  always @(negedge clk) begin
    #3;
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL unexpected_rsp: id %0d with empty scoreboard (cycle %0d)", rsp_id, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("rsp_id", int'(rsp_id), e.id);
        checkNear("rsp_cos", int'(rsp_cos), e.c);
        checkNear("rsp_sin", int'(rsp_sin), e.s);
      end
    end
  end

  // Returns just after the accept edge, i.e. #1 into the LAUNCH cycle.
  task automatic waitAccept(output int acc, output int grant);
    acc   = -1;
    grant = 0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (|(req_valid & req_ready)) begin
        acc   = cyc;
        grant = int'(req_valid & req_ready);
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) checkOutput("accept_timeout", 0, 1);
    else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitRsp(output int rc);
    rc = -1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (rsp_valid) begin
        rc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (rc < 0) checkOutput("rsp_timeout", 0, 1);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    checkOutput("drain_pending", exp_q.size(), 0);
  endtask

  task automatic applyStimulus(input int r, input int angle, input int c, input int s);
    int acc, g, rc;
    @(negedge clk);
    req_angle[r*WIDTH +: WIDTH] = angle;
    req_valid = N_REQ'(1 << r);
    rsp_ready = 1'b1;
    waitAccept(acc, g);
    checkOutput("single_grant", g, 1 << r);
    pushExp(r, c, s);
    req_valid = '0;
    checkOutput("busy_launch", int'(busy), 1);
    waitRsp(rc);
    checkOutput("rsp_latency", rc - acc, 20);
    checkOutput("busy_hold", int'(busy), 1);
    @(posedge clk);
    #1;
    checkOutput("busy_after", int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int acc, g, rc, prev, changes, bad_grant, snap_c, snap_s;
    rst       = 1'b1;
    req_valid = '0;
    req_angle = '0;
    rsp_ready = 1'b1;
    #12;
    req_valid = '1;
    #1;
    checkOutput("reset_req_ready", int'(req_ready), 0);
    checkOutput("reset_rsp_valid", int'(rsp_valid), 0);
    checkOutput("reset_rsp_id", int'(rsp_id), 0);
    checkOutput("reset_busy", int'(busy), 0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    // Single requests: 30 deg, 0 deg, -45 deg.
    applyStimulus(2, 1966080, 56756, 32768);
    applyStimulus(0, 0, 65536, 0);
    applyStimulus(3, -2949120, 46341, -46341);

    // Fairness with all requesters continuously valid.
    @(negedge clk);
    for (int r = 0; r < N_REQ; r++) req_angle[r*WIDTH +: WIDTH] = ang_tab[r];
    req_valid = '1;
    rsp_ready = 1'b1;
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      waitAccept(acc, g);
      checkOutput("rr_grant", g, 1 << (k % 4));
      pushExp(k % 4, cos_tab[k % 4], sin_tab[k % 4]);
      if (k > 0) checkOutput("rr_spacing", acc - prev, 21);
      prev = acc;
    end
    req_valid = '0;
    waitDrain();

    // Backpressure: hold the response for 10 cycles while requester 1 waits.
    @(negedge clk);
    rsp_ready = 1'b0;
    req_angle[1*WIDTH +: WIDTH] = 655360;
    req_angle[2*WIDTH +: WIDTH] = -2949120;
    req_valid = 4'b0110;
    waitAccept(acc, g);
    checkOutput("bp_grant", g, 4'b0100);
    pushExp(2, 46341, -46341);
    req_valid = 4'b0010;
    waitRsp(rc);
    snap_c  = int'(rsp_cos);
    snap_s  = int'(rsp_sin);
    changes = 0;
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_valid", int'(rsp_valid), 1);
      checkOutput("bp_req_ready", int'(req_ready), 0);
      checkOutput("bp_id", int'(rsp_id), 2);
      if (int'(rsp_cos) != snap_c || int'(rsp_sin) != snap_s) changes++;
      @(negedge clk);
      #1;
    end
    checkOutput("bp_stable_changes", changes, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checkOutput("bp_release_valid", int'(rsp_valid), 0);
    checkOutput("bp_next_ready", int'(req_ready), 4'b0010);
    waitAccept(acc, g);
    checkOutput("bp_next_grant", g, 4'b0010);
    checkOutput("bp_next_cycle", acc - rc, 11);
    pushExp(1, 64540, 11380);
    req_valid = '0;
    rsp_ready = 1'b1;
    waitDrain();

    // Reset in the middle of RUN aborts the operation.
    @(negedge clk);
    req_angle[3*WIDTH +: WIDTH] = 1966080;
    req_valid = 4'b1000;
    waitAccept(acc, g);
    checkOutput("rst_pre_grant", g, 4'b1000);
    req_valid = '0;
    for (int i = 0; i < 20; i++) begin
      if (cyc >= acc + 8) break;
      @(negedge clk);
    end
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_rsp_valid", int'(rsp_valid), 0);
    checkOutput("rst_rsp_id", int'(rsp_id), 0);
    checkOutput("rst_rsp_cos", int'(rsp_cos), 0);
    checkOutput("rst_rsp_sin", int'(rsp_sin), 0);
    checkOutput("rst_busy", int'(busy), 0);
    req_angle[0*WIDTH +: WIDTH] = 0;
    req_valid = '1;
    #1;
    checkOutput("rst_req_ready", int'(req_ready), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    waitAccept(acc, g);
    checkOutput("rst_first_grant", g, 4'b0001);
    pushExp(0, 65536, 0);
    req_valid = '0;

    // Requester 1 pulses only while requester 0 is in service.
    bad_grant = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid = (i >= 2 && i < 6) ? 4'b0010 : 4'b0000;
      #1;
      if (req_ready != '0) bad_grant++;
    end
    req_valid = '0;
    waitDrain();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (req_ready != '0 || rsp_valid) bad_grant++;
    end
    checkOutput("pulse_no_grant", bad_grant, 0);
    checkOutput("pulse_idle_busy", int'(busy), 0);
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
